// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } ahb_state_t;

endpackage

// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master: one local command becomes one NONSEQ word
// transfer; writes carry dina+dinb, reads capture hrdata into dout.
module ahb_master
    import ahb_pkg::*;
(
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        enable,
    input  logic [31:0] dina,
    input  logic [31:0] dinb,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic        hreadyout,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    input  logic [1:0]  slave_sel,
    output logic [1:0]  sel,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic        hmastlock,
    output logic        hready,
    output logic [31:0] hwdata,
    output logic [31:0] dout
);

    ahb_state_t  state_q, state_d;

    logic [1:0]  sel_d;
    logic [31:0] haddr_d;
    logic        hwrite_d;
    logic [1:0]  htrans_d;
    logic [31:0] hwdata_d;
    logic [31:0] dout_d;

    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DEFAULT;
    assign hmastlock = 1'b0;
    assign hready    = hreadyout;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_ADDR;
            ST_ADDR:  state_d = wr ? ST_WDATA : ST_RDATA;
            ST_WDATA,
            ST_RDATA: if (hreadyout) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus outputs; everything holds unless loaded.
    always_comb begin
        sel_d    = sel;
        haddr_d  = haddr;
        hwrite_d = hwrite;
        htrans_d = htrans;
        hwdata_d = hwdata;
        dout_d   = dout;
        case (state_q)
            ST_IDLE: begin
                htrans_d = HTRANS_IDLE;
            end
            ST_ADDR: begin
                haddr_d  = addr;
                hwrite_d = wr;
                sel_d    = slave_sel;
                htrans_d = HTRANS_NONSEQ;
                if (wr) begin
                    hwdata_d = dina + dinb;
                end
            end
            ST_WDATA: begin
                htrans_d = HTRANS_IDLE;
            end
            ST_RDATA: begin
                htrans_d = HTRANS_IDLE;
                if (hreadyout && (hresp == HRESP_OKAY)) begin
                    dout_d = hrdata;
                end
            end
            default: begin
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sel    <= '0;
            haddr  <= '0;
            hwrite <= 1'b0;
            htrans <= HTRANS_IDLE;
            hwdata <= '0;
            dout   <= '0;
        end else begin
            sel    <= sel_d;
            haddr  <= haddr_d;
            hwrite <= hwrite_d;
            htrans <= htrans_d;
            hwdata <= hwdata_d;
            dout   <= dout_d;
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: a driver acts as command source and AHB slave, a monitor
// checks each address phase and each completed transfer against queued expectations.
`timescale 1ns/1ps
module tb_ahb_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        enable;
    logic [31:0] dina, dinb, addr, hrdata;
    logic        wr, hreadyout, hresp;
    logic [1:0]  slave_sel;
    logic [1:0]  sel;
    logic [31:0] haddr, hwdata, dout;
    logic        hwrite, hmastlock, hready;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [1:0]  s;
        logic [31:0] wdata;
    } addr_exp_t;

    addr_exp_t   addr_q[$];
    logic [31:0] done_q[$];
    logic [31:0] model_dout;

    ahb_master dut (
        .hclk(hclk), .hresetn(hresetn), .enable(enable), .dina(dina), .dinb(dinb),
        .addr(addr), .wr(wr), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .slave_sel(slave_sel), .sel(sel), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
        .hmastlock(hmastlock), .hready(hready), .hwdata(hwdata), .dout(dout)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: phase 0 = no transfer, 1 = data phase in progress,
    // 2 = completing edge has passed, dout now checkable.
    initial begin
        int phase;
        addr_exp_t e;
        logic [31:0] d;
        phase = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                phase = 0;
                continue;
            end
            if (phase == 2) begin
                if (done_q.size() == 0) begin
                    chk("done_q_empty", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("dout", dout, d);
                end
                chk("htrans_after_done", {30'd0, htrans}, 32'd0);
                phase = 0;
            end else if (phase == 1) begin
                chk("htrans_wait", {30'd0, htrans}, 32'd0);
            end
            if (htrans == 2'b10) begin
                if (addr_q.size() == 0) begin
                    chk("addr_q_empty", 32'd1, 32'd0);
                end else begin
                    e = addr_q.pop_front();
                    chk("haddr", haddr, e.a);
                    chk("hwrite", {31'd0, hwrite}, {31'd0, e.w});
                    chk("sel", {30'd0, sel}, {30'd0, e.s});
                    if (e.w) chk("hwdata", hwdata, e.wdata);
                end
                phase = 1;
            end
            if (phase == 1 && hready) phase = 2;
        end
    end

    task automatic xfer(input bit w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] rd,
                        input int unsigned waits, input bit err, input bit abort);
        addr_exp_t e;
        @(posedge hclk); #1;
        enable = 1'b1; wr = w; addr = a; slave_sel = s; dina = x; dinb = y;
        hrdata = rd; hresp = err; hreadyout = (waits == 0);
        e.w = w; e.a = a; e.s = s; e.wdata = x + y;
        addr_q.push_back(e);
        if (!abort) begin
            if (!w && !err) model_dout = rd;
            done_q.push_back(model_dout);
        end
        @(posedge hclk); #1;
        enable = 1'b0;
        @(posedge hclk); #1;
        addr = $urandom; dina = $urandom; dinb = $urandom; wr = ~w; slave_sel = 2'(s + 1);
        if (abort) begin
            @(posedge hclk); #1;
            hresetn = 1'b0;
            #2;
            chk("rst_htrans", {30'd0, htrans}, 32'd0);
            chk("rst_haddr", haddr, 32'd0);
            chk("rst_hwdata", hwdata, 32'd0);
            chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
            chk("rst_sel", {30'd0, sel}, 32'd0);
            chk("rst_dout", dout, 32'd0);
            model_dout = '0;
            hreadyout = 1'b1; hresp = 1'b0;
            @(posedge hclk); #1;
            hresetn = 1'b1;
            return;
        end
        repeat (waits) begin
            @(posedge hclk); #1;
        end
        hreadyout = 1'b1;
        @(posedge hclk); #1;
        hresp = 1'b0;
        hrdata = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        hresetn = 1'b0; enable = 1'b0; dina = '0; dinb = '0; addr = '0; wr = 1'b0;
        hreadyout = 1'b1; hresp = 1'b0; hrdata = '0; slave_sel = '0;
        model_dout = '0;
        repeat (3) @(posedge hclk);
        #1;
        chk("reset_htrans", {30'd0, htrans}, 32'd0);
        chk("reset_haddr", haddr, 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_hsize", {29'd0, hsize}, 32'd2);
        chk("reset_hburst", {29'd0, hburst}, 32'd0);
        chk("reset_hprot", {28'd0, hprot}, 32'd3);
        chk("reset_hmastlock", {31'd0, hmastlock}, 32'd0);
        hreadyout = 1'b0; #1;
        chk("hready_pass0", {31'd0, hready}, 32'd0);
        hreadyout = 1'b1; #1;
        chk("hready_pass1", {31'd0, hready}, 32'd1);
        @(posedge hclk); #1;
        hresetn = 1'b1;

        xfer(1'b1, 32'd9, 2'b01, 32'd1, 32'd2, 32'd0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'd5, 2'b10, 32'd0, 32'd0, 32'hA5A5_0001, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'd7, 2'b11, 32'd0, 32'd0, 32'h1234_5678, 3, 1'b0, 1'b0);
        xfer(1'b0, 32'd8, 2'b00, 32'd0, 32'd0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);
        xfer(1'b0, 32'd9, 2'b01, 32'd0, 32'd0, 32'hCAFE_0000, 2, 1'b1, 1'b0);
        xfer(1'b1, 32'h100, 2'b10, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 1'b0, 1'b0);
        xfer(1'b1, 32'h200, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 5, 1'b0, 1'b1);
        xfer(1'b0, 32'h300, 2'b01, 32'd0, 32'd0, 32'h0BAD_F00D, 1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0), 1'b0);
        end

        repeat (4) @(posedge hclk);
        #1;
        chk("addr_q_drained", addr_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("final_dout", dout, model_dout);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
